// File: rtl/mod_cu.sv
// Control FSM for mod_dp: repeated-subtraction a mod b with quotient count and div-by-zero flag.
// Optional iteration ceiling with a partial result and err_tmo: define MOD_ITER_LIMIT_EN (uses ITER_MAX).
module mod_cu #(
  parameter int W        = 32,
  parameter int CNT_W    = 32,
  parameter int ITER_MAX = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     remainder,
  output logic [CNT_W-1:0] quotient,
  output logic             err_div0,
  output logic             err_tmo,
  output logic [W-1:0]     a_dp,
  output logic [W-1:0]     b_dp,
  output logic             s,
  output logic             we,
  input  logic             x,
  input  logic [W-1:0]     result_dp
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] ITER  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic             lim_hit;
  logic [CNT_W-1:0] q_inc;

`ifdef MOD_ITER_LIMIT_EN
  assign lim_hit = (state == ITER) && !x && (quotient == CNT_W'(ITER_MAX));
`else
  assign lim_hit = 1'b0;
  assign err_tmo = 1'b0;
`endif

  // Quotient saturates instead of wrapping.
  assign q_inc = (quotient == {CNT_W{1'b1}}) ? quotient : quotient + CNT_W'(1);

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign s    = (state == ITER);
  assign we   = (state == LOAD) || ((state == ITER) && !x && !lim_hit);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      a_dp      <= '0;
      b_dp      <= '0;
      remainder <= '0;
      quotient  <= '0;
      err_div0  <= 1'b0;
`ifdef MOD_ITER_LIMIT_EN
      err_tmo   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_dp     <= a_in;
            b_dp     <= b_in;
            quotient <= '0;
            err_div0 <= 1'b0;
`ifdef MOD_ITER_LIMIT_EN
            err_tmo  <= 1'b0;
`endif
            if (b_in == '0) begin
              err_div0  <= 1'b1;
              remainder <= '0;
              state     <= DONE;
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (x) begin
            remainder <= a_dp;
            quotient  <= '0;
            state     <= DONE;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: begin
          quotient <= CNT_W'(1);
          state    <= ITER;
        end
        ITER: begin
          if (lim_hit) begin
`ifdef MOD_ITER_LIMIT_EN
            err_tmo <= 1'b1;
`endif
            remainder <= result_dp;
            state     <= DONE;
          end else if (!x) begin
            quotient <= q_inc;
          end else begin
            remainder <= result_dp;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_cu.sv
// Directed bench for mod_cu with a behavioural mod_dp and an expected-result queue.
module tb_mod_cu;

  localparam int W     = 32;
  localparam int CNT_W = 32;
`ifdef MOD_ITER_LIMIT_EN
  localparam int IM = 4;
`else
  localparam int IM = 1024;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     a_in = '0;
  logic [W-1:0]     b_in = '0;
  logic             busy, done, err_div0, err_tmo, s, we, x;
  logic [W-1:0]     remainder, a_dp, b_dp, result_dp;
  logic [CNT_W-1:0] quotient;

  mod_cu #(.W(W), .CNT_W(CNT_W), .ITER_MAX(IM)) dut (
    .CLK(clk), .RST(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .remainder(remainder), .quotient(quotient),
    .err_div0(err_div0), .err_tmo(err_tmo), .a_dp(a_dp), .b_dp(b_dp),
    .s(s), .we(we), .x(x), .result_dp(result_dp)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: temp <= selected - b on we; x = selected < b.
  logic [W-1:0] temp;
  logic [W-1:0] sel;
  assign sel       = s ? temp : a_dp;
  assign x         = (sel < b_dp);
  assign result_dp = temp;
  always_ff @(posedge clk) begin
    if (rst) temp <= '0;
    else if (we) temp <= sel - b_dp;
  end

  typedef struct {
    logic [W-1:0]     rem;
    logic [CNT_W-1:0] quo;
    logic             div0;
    logic             tmo;
    int               lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
    exp_t e;
    logic [63:0] q64;
    int cyc, we_cnt, s_cnt, busy_bad;
    e.div0 = 1'b0; e.tmo = 1'b0;
    if (b == 0) begin
      e.rem = '0; e.quo = '0; e.div0 = 1'b1; e.lat = 1;
    end else if (a < b) begin
      e.rem = a; e.quo = '0; e.lat = 2;
    end else begin
      q64 = 64'(a) / 64'(b);
      e.rem = a % b;
`ifdef MOD_ITER_LIMIT_EN
      if (q64 > 64'(IM)) begin
        q64 = 64'(IM);
        e.rem = W'(64'(a) - q64 * 64'(b));
        e.tmo = 1'b1;
      end
`endif
      e.quo = CNT_W'(q64);
      e.lat = int'(q64) + 3;
    end
    exp_q.push_back(e);

    a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; we_cnt = 0; s_cnt = 0; busy_bad = 0;
    while (!done && cyc < 300) begin
      we_cnt += int'(we);
      s_cnt  += int'(s);
      if (!busy) busy_bad++;
      if (cyc == inj) begin
        start = 1'b1; a_in = 99; b_in = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      chk("done_timeout", 64'(done), 64'(1));
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    chk("latency",   64'(cyc), 64'(e.lat));
    chk("remainder", 64'(remainder), 64'(e.rem));
    chk("quotient",  64'(quotient), 64'(e.quo));
    chk("err_div0",  64'(err_div0), 64'(e.div0));
    chk("err_tmo",   64'(err_tmo), 64'(e.tmo));
    chk("we_cycles", 64'(we_cnt), 64'(e.quo));
    chk("s_cycles",  64'(s_cnt), 64'(e.quo));
    chk("busy_hold", 64'(busy_bad), 64'(0));
    chk("done_s_we", {62'd0, s, we}, 64'(0));
    chk("done_busy", 64'(busy), 64'(1));
    @(negedge clk);
    chk("done_pulse", {62'd0, done, busy}, 64'(0));
    chk("rem_held",   64'(remainder), 64'(e.rem));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ctl",  {58'd0, busy, done, s, we, err_div0, err_tmo}, 64'(0));
    chk("rst_rem",  64'(remainder), 64'(0));
    chk("rst_quo",  64'(quotient), 64'(0));
    chk("rst_adp",  64'(a_dp), 64'(0));
    chk("rst_bdp",  64'(b_dp), 64'(0));

    run_op(38, 7, 0);
    run_op(5, 9, 0);
    run_op(12, 0, 0);
    run_op(21, 7, 0);
    run_op(22, 7, 0);
    run_op(7, 7, 0);
    run_op(0, 5, 0);
    run_op(255, 16, 0);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(100, 3, 0);
    // start with a zero divisor injected mid-operation must be ignored
    run_op(38, 7, 3);

    // Abort a long operation with reset; no done may appear.
    a_in = 1000; b_in = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      chk("abort_nodone", 64'(done), 64'(0));
      if (c == 3) begin
        start = 1'b1; a_in = 5; b_in = '0;
      end else begin
        start = 1'b0;
      end
      if (c < 9) @(negedge clk);
    end
    start = 1'b0;
    chk("abort_adp", 64'(a_dp), 64'(1000));
    chk("abort_bdp", 64'(b_dp), 64'(1));
    chk("abort_quo", 64'(quotient), 64'(7));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ctl", {58'd0, busy, done, s, we, err_div0, err_tmo}, 64'(0));
    chk("abort_dat", {32'(remainder), 32'(quotient)}, 64'(0));
    chk("abort_dp",  {32'(a_dp), 32'(b_dp)}, 64'(0));
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle", {62'd0, busy, done}, 64'(0));
    end

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; a_in = 50; b_in = 3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_beats_start", {31'd0, busy, 32'(a_dp)}, 64'(0));

    run_op(22, 7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
